// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared FSM states and sizing helpers for the instruction loader.
package instr_loader_pkg;
  typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [63:0] ones(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/instr_loader_strobe_sync.sv
// strobe_sync: synchronises the load button, detects the selected edge(s) and delays the switch value to match.
module strobe_sync #(
  parameter int W = 8,
  parameter int STAGES = 2,
  parameter int EDGE_MODE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_but,
  input  logic [W-1:0] i_data,
  output logic         o_strobe,
  output logic [W-1:0] o_data
);
  logic [STAGES-1:0]        r_sync;
  logic [STAGES-1:0][W-1:0] r_dly;
  logic [STAGES:0]          r_vld;
  logic                     r_last;
  logic                     w_stb;
  // r_vld masks the phantom edge seen while the chain refills after reset
  assign w_stb = r_vld[STAGES] && ((EDGE_MODE != 0) ? (r_sync[STAGES-1] ^ r_last)
                                                    : (r_sync[STAGES-1] & ~r_last));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_dly    <= '0;
      r_vld    <= '0;
      r_last   <= 1'b0;
      o_strobe <= 1'b0;
      o_data   <= '0;
    end else begin
      r_sync   <= {r_sync[STAGES-2:0], i_but};
      r_dly    <= {r_dly[STAGES-2:0], i_data};
      r_vld    <= {r_vld[STAGES-1:0], 1'b1};
      r_last   <= r_sync[STAGES-1];
      o_strobe <= w_stb;
      o_data   <= r_dly[STAGES-1];
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: button-strobed program loader with end-code/full termination.
// Define HAZARD_SCAN_EN to add a post-load RAW hazard scan (SCAN state).
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int DEPTH = 8,
  parameter logic [INSTR_W-1:0] END_CODE = INSTR_W'(ones(INSTR_W)),
  parameter int EDGE_MODE = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LSB = 3,
  parameter int RS_LSB = 0,
  parameter int REG_W = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INSTR_W-1:0]           input_val,
  input  logic                         but_inp,
  input  logic                         clear,
  output logic [DEPTH*INSTR_W-1:0]     instrMemBits,
  output logic [$clog2(DEPTH+1)-1:0]   instr_count,
  output logic                         load_done,
  output logic                         full,
  output logic [DEPTH-1:0]             hazardMemBits,
  output logic                         hazard_valid
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = idx_w(DEPTH);
`ifdef HAZARD_SCAN_EN
  localparam state_t END_ST = SCAN;
`else
  localparam state_t END_ST = DONE;
`endif
  state_t             r_state, w_next;
  logic [INSTR_W-1:0] r_slot [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic               w_stb, w_wr;
  logic [INSTR_W-1:0] w_data;
  strobe_sync #(.W(INSTR_W), .STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE)) u_sync (
    .clk(clk), .reset(reset), .i_but(but_inp), .i_data(input_val),
    .o_strobe(w_stb), .o_data(w_data)
  );
`ifdef HAZARD_SCAN_EN
  logic [IDX_W-1:0] r_k, w_last_k;
  logic [DEPTH-1:0] r_haz;
  logic             w_hz;
  assign w_last_k = (r_count == '0) ? '0 : IDX_W'(r_count - 1'b1);
  assign w_hz = (r_k != '0) &&
                (r_slot[r_k][RS_LSB +: REG_W] == r_slot[r_k - 1'b1][RD_LSB +: REG_W]);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_k   <= '0;
      r_haz <= '0;
    end else if (r_state == SCAN) begin
      r_haz[r_k] <= w_hz;
      r_k        <= r_k + 1'b1;
    end
  end
  assign hazardMemBits = r_haz;
  assign hazard_valid  = r_state == DONE;
`else
  logic w_unused;
  assign w_unused      = ^{RD_LSB, RS_LSB, REG_W};
  assign hazardMemBits = '0;
  assign hazard_valid  = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_wr = w_stb && (w_data != END_CODE);
        if (w_stb) w_next = (!w_wr || r_count == CNT_W'(DEPTH - 1)) ? END_ST : LOAD;
      end
`ifdef HAZARD_SCAN_EN
      SCAN: w_next = (r_k == w_last_k) ? DONE : SCAN;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || clear) r_state <= LOAD;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
    end else if (w_wr) begin
      r_slot[IDX_W'(r_count)] <= w_data;
      r_count                 <= r_count + 1'b1;
    end
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_img
    assign instrMemBits[k*INSTR_W +: INSTR_W] = r_slot[k];
  end
  assign instr_count = r_count;
  assign load_done   = r_state == DONE;
  assign full        = r_count == CNT_W'(DEPTH);
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: drives both edge modes side by side and checks them against a slot-level program model.
module tb_instr_loader;
  logic       clk = 1'b0, reset = 1'b1, clear = 1'b0, but_inp = 1'b1;
  logic [7:0] input_val = 8'h00;
  logic [63:0] img1, img0;
  logic [3:0]  cnt1, cnt0;
  logic        done1, done0, full1, full0, hv1, hv0;
  logic [7:0]  haz1, haz0;
  int          n_chk = 0, n_err = 0;
  logic [7:0]  m_slot [2][8];
  int          m_cnt [2];
  bit          m_done [2];

  always #5 clk = ~clk;

  instr_loader #(.EDGE_MODE(1)) u1 (
    .clk(clk), .reset(reset), .input_val(input_val), .but_inp(but_inp), .clear(clear),
    .instrMemBits(img1), .instr_count(cnt1), .load_done(done1), .full(full1),
    .hazardMemBits(haz1), .hazard_valid(hv1));
  instr_loader #(.EDGE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .input_val(input_val), .but_inp(but_inp), .clear(clear),
    .instrMemBits(img0), .instr_count(cnt0), .load_done(done0), .full(full0),
    .hazardMemBits(haz0), .hazard_valid(hv0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0;
      m_done[m] = 0;
      for (int k = 0; k < 8; k++) m_slot[m][k] = 8'h00;
    end
  endtask

  task automatic m_take(input int m, input logic [7:0] v);
    if (!m_done[m]) begin
      if (v == 8'hFF) m_done[m] = 1;
      else begin
        m_slot[m][m_cnt[m]] = v;
        m_cnt[m]++;
        if (m_cnt[m] == 8) m_done[m] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] e_img;
    logic [7:0]  e_haz;
    for (int m = 0; m < 2; m++) begin
      e_img = '0;
      e_haz = '0;
      for (int k = 0; k < 8; k++) e_img[k*8 +: 8] = m_slot[m][k];
`ifdef HAZARD_SCAN_EN
      if (m_done[m])
        for (int k = 1; k < m_cnt[m]; k++)
          e_haz[k] = (m_slot[m][k][2:0] == m_slot[m][k-1][5:3]);
`endif
      chk({tag, (m != 0) ? "/e1/img" : "/e0/img"}, (m != 0) ? img1 : img0, e_img);
      chk({tag, (m != 0) ? "/e1/cnt" : "/e0/cnt"}, (m != 0) ? cnt1 : cnt0, 64'(m_cnt[m]));
      chk({tag, (m != 0) ? "/e1/done" : "/e0/done"}, (m != 0) ? done1 : done0, 64'(m_done[m]));
      chk({tag, (m != 0) ? "/e1/full" : "/e0/full"}, (m != 0) ? full1 : full0, 64'(m_cnt[m] == 8));
      chk({tag, (m != 0) ? "/e1/haz" : "/e0/haz"}, (m != 0) ? haz1 : haz0, 64'(e_haz));
`ifdef HAZARD_SCAN_EN
      chk({tag, (m != 0) ? "/e1/hv" : "/e0/hv"}, (m != 0) ? hv1 : hv0, 64'(m_done[m]));
`else
      chk({tag, (m != 0) ? "/e1/hv" : "/e0/hv"}, (m != 0) ? hv1 : hv0, 64'(0));
`endif
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    input_val = v;
    repeat (2) @(posedge clk);
    #1 but_inp = ~but_inp;
    m_take(1, v);
    if (but_inp) m_take(0, v);
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_clear();
  endtask

  logic [7:0] seq1 [8] = '{8'h88, 8'h89, 8'h8A, 8'h8C, 8'h90, 8'hA8, 8'h89, 8'hFF};
  logic [7:0] v;

  initial begin
    m_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 check_all("reset");
    foreach (seq1[i]) strobe(seq1[i]);
    check_all("seq");
    chk("t1_img", img1, 64'h0089_A890_8C8A_8988);
    chk("t1_cnt", cnt1, 64'd7);
    chk("t1_full", full1, 64'd0);
    chk("t2_img", img0, 64'h0000_0000_00A8_8C89);
    chk("t2_cnt", cnt0, 64'd3);
    chk("t2_done", done0, 64'd1);
    do_clear();
    #1 check_all("clear");
    for (int i = 1; i <= 8; i++) strobe(8'(i));
    chk("t3_full", full1, 64'd1);
    chk("t3_done", done1, 64'd1);
    strobe(8'h11);
    strobe(8'h22);
    check_all("full");
    chk("t3_slot0", img1[7:0], 64'h01);
    do_clear();
    strobe(8'h31);
    strobe(8'h32);
    strobe(8'h33);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_clear();
    repeat (6) @(posedge clk);
    strobe(8'h44);
    strobe(8'hFF);
    check_all("rst_mid");
    chk("t4_cnt", cnt1, 64'd1);
    chk("t4_img", img1, 64'h44);
    do_clear();
    input_val = 8'h55;
    repeat (2) @(posedge clk);
    #1 but_inp = ~but_inp;
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("t6_drop_cnt", cnt1, 64'd0);
    check_all("drop");
    input_val = 8'h66;
    repeat (2) @(posedge clk);
    #1 but_inp = ~but_inp;
    m_take(1, 8'h66);
    if (but_inp) m_take(0, 8'h66);
    repeat (3) @(posedge clk);
    #1 chk("lat_early", cnt1, 64'd0);
    @(posedge clk);
    #1 chk("lat_due", cnt1, 64'd1);
    chk("lat_img", img1[7:0], 64'h66);
    repeat (12) @(posedge clk);
    #1 check_all("lat");
    do_clear();
    strobe(8'hFF);
    chk("t6_ff_done", done1, 64'd1);
    chk("t6_ff_cnt", cnt1, 64'd0);
    check_all("ff_first");
    do_clear();
    strobe(8'h18);
    strobe(8'h03);
    strobe(8'h21);
    strobe(8'hFF);
    check_all("haz");
`ifdef HAZARD_SCAN_EN
    chk("t5_haz", haz1, 64'b0000_0010);
    chk("t5_hv", hv1, 64'd1);
`endif
    for (int r = 0; r < 3; r++) begin
      do_clear();
      for (int i = 0; i < 10; i++) begin
        v = ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom);
        strobe(v);
        check_all("rand");
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
